// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS decode stage: instruction types, opcodes,
// field positions and the decoded-entry record stored in the FIFO.
package decode_pkg;

    typedef enum logic [1:0] {
        TYPE_R       = 2'd0,
        TYPE_I       = 2'd1,
        TYPE_J       = 2'd2,
        TYPE_ILLEGAL = 2'd3
    } instr_type_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int TARGET_HI = 25;

    typedef struct packed {
        instr_type_e itype;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [31:0] target;
        logic [31:0] pc;
    } decoded_t;

    function automatic instr_type_e classify(input logic [5:0] op);
        case (op)
            OP_SPECIAL:                                 return TYPE_R;
            OP_J, OP_JAL:                               return TYPE_J;
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LB, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH,
            OP_SW:                                      return TYPE_I;
            default:                                    return TYPE_ILLEGAL;
        endcase
    endfunction

    // Logical immediates zero-extend; everything else sign-extends.
    function automatic logic imm_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between the instruction producer, the decode stage and its consumer.
// Valid/ready: a beat moves on a rising edge with valid && ready; valid never waits on ready.
interface decode_stage_if;
    import decode_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    instr_type_e out_type;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [31:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_type, out_opcode, out_rs, out_rt,
               out_rd, out_shamt, out_funct, out_imm, out_target, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_type, out_opcode, out_rs, out_rt,
               out_rd, out_shamt, out_funct, out_imm, out_target, out_pc
    );

endinterface

// File: rtl/instr_fields.sv
// Combinational MIPS field extraction and classification; unused fields of
// each format are forced to zero so the stored entry is canonical.
module instr_fields
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output decoded_t    o_dec
);

    logic [5:0]  w_opcode;
    logic [15:0] w_imm16;
    logic [3:0]  w_pc4_hi;
    instr_type_e w_type;

    assign w_opcode = i_instr[OPCODE_HI:OPCODE_LO];
    assign w_imm16  = i_instr[IMM_HI:0];
    assign w_type   = classify(w_opcode);
    // Top nibble of pc+4: bits [27:2] all ones means the +4 carries into bit 28.
    assign w_pc4_hi = i_pc[31:28] + 4'(&i_pc[27:2]);

    always_comb begin
        o_dec        = '0;
        o_dec.itype  = w_type;
        o_dec.opcode = w_opcode;
        o_dec.pc     = i_pc;
        case (w_type)
            TYPE_R: begin
                o_dec.rs    = i_instr[RS_HI:RS_LO];
                o_dec.rt    = i_instr[RT_HI:RT_LO];
                o_dec.rd    = i_instr[RD_HI:RD_LO];
                o_dec.shamt = i_instr[SHAMT_HI:SHAMT_LO];
                o_dec.funct = i_instr[FUNCT_HI:FUNCT_LO];
            end
            TYPE_I: begin
                o_dec.rs  = i_instr[RS_HI:RS_LO];
                o_dec.rt  = i_instr[RT_HI:RT_LO];
                o_dec.imm = imm_zero_ext(w_opcode) ? {16'h0000, w_imm16}
                                                   : {{16{w_imm16[15]}}, w_imm16};
            end
            TYPE_J: begin
                o_dec.target = {w_pc4_hi, i_instr[TARGET_HI:0], 2'b00};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: classifies each accepted instruction and buffers the decoded
// entry in a small FIFO; also counts accepted illegal instructions (saturating).
module decode_stage
    import decode_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    decoded_t         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_illegal_cnt;

    decoded_t w_dec;
    decoded_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;

    instr_fields u_fields (
        .i_instr (bus.in_instr),
        .i_pc    (bus.in_pc),
        .o_dec   (w_dec)
    );

    // in_ready comes only from registered occupancy, never from out_ready.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = !w_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && (w_dec.itype == TYPE_ILLEGAL) && (r_illegal_cnt != '1)) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

    // Empty FIFO presents an all-zero entry rather than stale memory.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.in_ready   = !w_full;
    assign bus.out_valid  = !w_empty;
    assign bus.out_type   = w_head.itype;
    assign bus.out_opcode = w_head.opcode;
    assign bus.out_rs     = w_head.rs;
    assign bus.out_rt     = w_head.rt;
    assign bus.out_rd     = w_head.rd;
    assign bus.out_shamt  = w_head.shamt;
    assign bus.out_funct  = w_head.funct;
    assign bus.out_imm    = w_head.imm;
    assign bus.out_target = w_head.target;
    assign bus.out_pc     = w_head.pc;
    assign illegal_cnt    = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors plus a random stream, checked
// against a reference decode model through an expected-entry queue.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;
    localparam int VEC_W      = 130;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] illegal_cnt;

    int               tests_run    = 0;
    int               tests_failed = 0;
    logic [VEC_W-1:0] exp_q[$];
    logic [VEC_W-1:0] mon_exp;
    logic [CNT_W-1:0] exp_illegal;
    bit               stream_done;

    decode_stage_if bus ();

    decode_stage #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] pack_exp(
        input logic [1:0]  t,
        input logic [5:0]  op,
        input logic [4:0]  rs, rt, rd, sh,
        input logic [5:0]  fn,
        input logic [31:0] imm, tgt, pc
    );
        return {t, op, rs, rt, rd, sh, fn, imm, tgt, pc};
    endfunction

    function automatic logic [VEC_W-1:0] model(input logic [31:0] instr, input logic [31:0] pc);
        logic [5:0]  op;
        logic [31:0] pc4;
        logic [31:0] imm;
        op  = instr[31:26];
        pc4 = pc + 32'd4;
        if (op == 6'h00)
            return pack_exp(2'd0, op, instr[25:21], instr[20:16], instr[15:11], instr[10:6],
                            instr[5:0], 32'd0, 32'd0, pc);
        if (op == 6'h02 || op == 6'h03)
            return pack_exp(2'd2, op, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0,
                            {pc4[31:28], instr[25:0], 2'b00}, pc);
        if ((op inside {6'h04, 6'h05, 6'h20, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B}) ||
            (op >= 6'h08 && op <= 6'h0F)) begin
            if (op >= 6'h0C && op <= 6'h0E) imm = {16'h0000, instr[15:0]};
            else                            imm = {{16{instr[15]}}, instr[15:0]};
            return pack_exp(2'd1, op, instr[25:21], instr[20:16], 5'd0, 5'd0, 6'd0, imm, 32'd0, pc);
        end
        return pack_exp(2'd3, op, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 32'd0, pc);
    endfunction

    function automatic logic [VEC_W-1:0] get_head();
        return {bus.out_type, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
                bus.out_funct, bus.out_imm, bus.out_target, bus.out_pc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        w = $urandom;
        case ($urandom_range(0, 7))
            0:       op = 6'h00;
            1:       op = 6'h02;
            2:       op = 6'h03;
            3:       op = 6'($urandom_range(12, 14));
            4:       op = 6'h23;
            5:       op = 6'h08;
            6:       op = 6'h2B;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, w[25:0]};
    endfunction

    // Scoreboard: every pop the DUT performs is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_unexpected: got %h, required no output", get_head());
            end else begin
                mon_exp = exp_q.pop_front();
                if (get_head() !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL scoreboard_entry: got %h, required %h", get_head(), mon_exp);
                end
            end
        end
    end

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        int               cyc;
        logic [VEC_W-1:0] m;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        cyc = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: in_ready=%b, required 1", bus.in_ready);
        end else begin
            m = model(instr, pc);
            exp_q.push_back(m);
            if (m[VEC_W-1 -: 2] == 2'd3 && exp_illegal != '1) exp_illegal++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        bus.out_ready = 1'b0;
        tests_run++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: pending=%0d out_valid=%b, required 0 and 0",
                     exp_q.size(), bus.out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_illegal = '0;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        tests_run++;
        if (illegal_cnt !== '0) begin
            tests_failed++; $display("FAIL reset_illegal_cnt: got %0d, required 0", illegal_cnt);
        end
        tests_run++;
        if (get_head() !== '0) begin
            tests_failed++; $display("FAIL reset_data_zero: got %h, required 0", get_head());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_r_type();
        logic [VEC_W-1:0] e;
        bus.out_ready = 1'b0;
        push_one(32'h00221905, 32'h0000_0000);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL r_latency: out_valid=%b, required 1", bus.out_valid);
        end
        e = pack_exp(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 32'd0, 32'd0, 32'd0);
        tests_run++;
        if (get_head() !== e) begin
            tests_failed++; $display("FAIL r_fields: got %h, required %h", get_head(), e);
        end
        drain();
    endtask

    task automatic test_i_type();
        logic [31:0]      instrs [3];
        logic [31:0]      imms   [3];
        logic [5:0]       ops    [3];
        logic [VEC_W-1:0] e;
        instrs = '{32'h8C220003, 32'h3022FFFF, 32'h8C22FFFF};
        imms   = '{32'h00000003, 32'h0000FFFF, 32'hFFFFFFFF};
        ops    = '{6'h23, 6'h0C, 6'h23};
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_one(instrs[k], 32'h100 + 32'(k * 4));
            e = pack_exp(2'd1, ops[k], 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, imms[k], 32'd0,
                         32'h100 + 32'(k * 4));
            tests_run++;
            if (get_head() !== e) begin
                tests_failed++; $display("FAIL i_fields_%0d: got %h, required %h", k, get_head(), e);
            end
            drain();
        end
    endtask

    task automatic test_j_type();
        logic [31:0]      pcs  [2];
        logic [31:0]      tgts [2];
        logic [VEC_W-1:0] e;
        pcs  = '{32'h40000000, 32'hFFFFFFFC};
        tgts = '{32'h4000000C, 32'h0000000C};
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_one(32'h08000003, pcs[k]);
            e = pack_exp(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, tgts[k], pcs[k]);
            tests_run++;
            if (get_head() !== e) begin
                tests_failed++; $display("FAIL j_target_%0d: got %h, required %h", k, get_head(), e);
            end
            drain();
        end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_one({6'h3F, 26'($urandom)}, 32'h300 + 32'(k * 4));
            tests_run++;
            if (bus.out_type !== TYPE_ILLEGAL || bus.out_opcode !== 6'h3F) begin
                tests_failed++;
                $display("FAIL illegal_type_%0d: type=%0d opcode=%h, required 3 and 3f",
                         k, bus.out_type, bus.out_opcode);
            end
            drain();
            if (k >= 2) begin
                tests_run++;
                if (illegal_cnt !== 2'd3) begin
                    tests_failed++;
                    $display("FAIL illegal_cnt_%0d: got %0d, required 3", k, illegal_cnt);
                end
            end
        end
    endtask

    task automatic test_full_hold();
        logic [VEC_W-1:0] held;
        bus.out_ready = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) push_one(rand_instr(), 32'h500 + 32'(k * 4));
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL full_in_ready: got %b, required 0", bus.in_ready);
        end
        held = get_head();
        tests_run++;
        if (held !== exp_q[0]) begin
            tests_failed++; $display("FAIL full_head: got %h, required %h", held, exp_q[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (get_head() !== held) begin
            tests_failed++; $display("FAIL hold_stable: got %h, required %h", get_head(), held);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL pop_in_ready: got %b, required 1", bus.in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        stream_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) push_one(rand_instr(), 32'($urandom) & 32'hFFFF_FFFC);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        tests_run++;
        if (illegal_cnt !== exp_illegal) begin
            tests_failed++; $display("FAIL stream_illegal_cnt: got %0d, required %0d", illegal_cnt, exp_illegal);
        end
    endtask

    task automatic test_reset_midstream();
        for (int fill = 2; fill >= 1; fill--) begin
            bus.out_ready = 1'b0;
            push_one({6'h3F, 26'h1}, 32'h200);
            if (fill == 2) push_one(32'h00221905, 32'h204);
            bus.in_valid = 1'b1;
            bus.in_instr = 32'hFC00BEEF;
            bus.in_pc    = 32'h208;
            reset        = 1'b1;
            @(posedge clk);
            #1;
            reset        = 1'b0;
            bus.in_valid = 1'b0;
            exp_q.delete();
            exp_illegal = '0;
            @(negedge clk);
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || illegal_cnt !== '0) begin
                tests_failed++;
                $display("FAIL midreset_%0d: out_valid=%b in_ready=%b illegal_cnt=%0d, required 0 1 0",
                         fill, bus.out_valid, bus.in_ready, illegal_cnt);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
        bus.out_ready = 1'b0;
        push_one(32'h08000003, 32'h40000000);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        exp_illegal   = '0;
        stream_done   = 1'b0;
        test_reset();
        test_r_type();
        test_i_type();
        test_j_type();
        test_illegal();
        test_full_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
